// File: rtl/cpu64_tl_pkg.sv
// TileLink-C constants and the L1 eviction engine state type.
package cpu64_tl_pkg;

   // Channel C / D opcodes used by the eviction path.
   localparam logic [2:0] TL_RELEASE      = 3'd6;
   localparam logic [2:0] TL_RELEASE_DATA = 3'd7;
   localparam logic [2:0] TL_RELEASE_ACK  = 3'd6;

   // Shrink/report params.
   localparam logic [2:0] TL_SHRINK_TTOB = 3'd0;
   localparam logic [2:0] TL_SHRINK_TTON = 3'd1;
   localparam logic [2:0] TL_SHRINK_BTON = 3'd2;
   localparam logic [2:0] TL_SHRINK_TTOT = 3'd3;
   localparam logic [2:0] TL_SHRINK_BTOB = 3'd4;
   localparam logic [2:0] TL_SHRINK_NTON = 3'd5;

   // Line permission encodings held in the L1 tag array.
   localparam logic [1:0] PERM_N = 2'd0;
   localparam logic [1:0] PERM_B = 2'd1;
   localparam logic [1:0] PERM_T = 2'd2;

   // 64-byte line moved as 8 beats of 64 bits.
   localparam int         LINE_BEATS   = 8;
   localparam int         LINE_OFF_W   = 6;
   localparam logic [2:0] TL_SIZE_LINE = 3'd6;

   typedef enum logic [2:0] {
      EV_IDLE,
      EV_RD,
      EV_SEND,
      EV_WAIT_ACK,
      EV_FIN
   } evict_state_e;

endpackage

// File: rtl/cpu64_l1_evict.sv
// L1 victim eviction engine: releases the PLRU victim line on TileLink-C,
// waits for ReleaseAck, then invalidates the way and reports completion.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | ready for a request; request fields captured on accept
//   RD       | one-cycle read strobe to the data array for the current beat
//   SEND     | C beat presented, fields held until c_ready_i
//   WAIT_ACK | waiting for a ReleaseAck with our source id on D
//   FIN      | one cycle: done pulse, plus invalidate if the line was live
module cpu64_l1_evict
   import cpu64_tl_pkg::*;
#(
   parameter int INDEX_W   = 5,
   parameter int ADDR_W    = 32,
   parameter int TAG_W     = ADDR_W - INDEX_W - LINE_OFF_W,
   parameter int SOURCE_ID = 0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [INDEX_W-1:0] req_set_i,
   input  logic [2:0]         req_way_i,
   input  logic [TAG_W-1:0]   req_tag_i,
   input  logic               req_line_valid_i,
   input  logic               req_dirty_i,
   input  logic [1:0]         req_perm_i,
   output logic               rd_en_o,
   output logic [INDEX_W-1:0] rd_set_o,
   output logic [2:0]         rd_way_o,
   output logic [2:0]         rd_beat_o,
   input  logic [63:0]        rd_data_i,
   output logic               c_valid_o,
   input  logic               c_ready_i,
   output logic [2:0]         c_opcode_o,
   output logic [2:0]         c_param_o,
   output logic [2:0]         c_size_o,
   output logic [3:0]         c_source_o,
   output logic [ADDR_W-1:0]  c_address_o,
   output logic [63:0]        c_data_o,
   input  logic               d_valid_i,
   output logic               d_ready_o,
   input  logic [2:0]         d_opcode_i,
   input  logic [3:0]         d_source_i,
   output logic               inval_o,
   output logic [INDEX_W-1:0] inval_set_o,
   output logic [2:0]         inval_way_o,
   output logic               done_o,
   output logic               busy_o
);

   evict_state_e       state_q, state_d;
   logic [INDEX_W-1:0] set_q;
   logic [2:0]         way_q;
   logic [TAG_W-1:0]   tag_q;
   logic               dirty_q;
   logic [1:0]         perm_q;
   logic               inval_q;
   logic [2:0]         beat_q;
   logic [63:0]        data_q;
   logic               fresh_q;

   logic req_fire;
   logic c_fire;
   logic last_beat;
   logic ack_match;

   assign req_fire  = (state_q == EV_IDLE) && req_valid_i;
   assign c_fire    = (state_q == EV_SEND) && c_ready_i;
   assign last_beat = (beat_q == 3'(LINE_BEATS - 1));
   assign ack_match = (d_opcode_i == TL_RELEASE_ACK) && (d_source_i == 4'(SOURCE_ID));

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= EV_IDLE;
      else       state_q <= state_d;
   end

   // request capture, beat counter and beat data register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         set_q   <= '0;
         way_q   <= '0;
         tag_q   <= '0;
         dirty_q <= 1'b0;
         perm_q  <= PERM_N;
         inval_q <= 1'b0;
         beat_q  <= '0;
         data_q  <= '0;
         fresh_q <= 1'b0;
      end else begin
         if (req_fire) begin
            set_q   <= req_set_i;
            way_q   <= req_way_i;
            tag_q   <= req_tag_i;
            dirty_q <= req_dirty_i;
            perm_q  <= req_perm_i;
            inval_q <= req_line_valid_i && (req_perm_i != PERM_N);
            beat_q  <= '0;
         end else if (c_fire && dirty_q && !last_beat) begin
            beat_q <= beat_q + 3'd1;
         end
         // Array data arrives the cycle after the strobe; keep it for stalls.
         fresh_q <= (state_q == EV_RD);
         if (fresh_q) data_q <= rd_data_i;
      end
   end

   // next state and outputs; bus fields are zero whenever their strobe is low
   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      rd_en_o     = 1'b0;
      rd_set_o    = '0;
      rd_way_o    = '0;
      rd_beat_o   = '0;
      c_valid_o   = 1'b0;
      c_opcode_o  = '0;
      c_param_o   = '0;
      c_size_o    = '0;
      c_source_o  = '0;
      c_address_o = '0;
      c_data_o    = '0;
      d_ready_o   = 1'b0;
      inval_o     = 1'b0;
      inval_set_o = '0;
      inval_way_o = '0;
      done_o      = 1'b0;
      busy_o      = (state_q != EV_IDLE);
      unique case (state_q)
         EV_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               if (!req_line_valid_i || (req_perm_i == PERM_N)) state_d = EV_FIN;
               else if (req_dirty_i)                            state_d = EV_RD;
               else                                             state_d = EV_SEND;
            end
         end
         EV_RD: begin
            rd_en_o   = 1'b1;
            rd_set_o  = set_q;
            rd_way_o  = way_q;
            rd_beat_o = beat_q;
            state_d   = EV_SEND;
         end
         EV_SEND: begin
            c_valid_o   = 1'b1;
            c_opcode_o  = dirty_q ? TL_RELEASE_DATA : TL_RELEASE;
            c_param_o   = (perm_q == PERM_T) ? TL_SHRINK_TTON :
                          (perm_q == PERM_B) ? TL_SHRINK_BTON : TL_SHRINK_NTON;
            c_size_o    = TL_SIZE_LINE;
            c_source_o  = 4'(SOURCE_ID);
            c_address_o = {tag_q, set_q, {LINE_OFF_W{1'b0}}};
            // First SEND cycle after a read forwards the array output directly.
            if (dirty_q) c_data_o = fresh_q ? rd_data_i : data_q;
            if (c_ready_i) state_d = (dirty_q && !last_beat) ? EV_RD : EV_WAIT_ACK;
         end
         EV_WAIT_ACK: begin
            d_ready_o = ack_match;
            if (d_valid_i && ack_match) state_d = EV_FIN;
         end
         EV_FIN: begin
            done_o = 1'b1;
            if (inval_q) begin
               inval_o     = 1'b1;
               inval_set_o = set_q;
               inval_way_o = way_q;
            end
            state_d = EV_IDLE;
         end
         default: state_d = EV_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cpu64_l1_evict.sv
// Self-checking bench for cpu64_l1_evict: transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then
// randomized requests and bus back-pressure.
module tb_cpu64_l1_evict;

   localparam int INDEX_W = 5;
   localparam int ADDR_W  = 32;
   localparam int TAG_W   = ADDR_W - INDEX_W - 6;

   localparam int P_IDLE = 0;
   localparam int P_BUS  = 1;
   localparam int P_ACK  = 2;
   localparam int P_FIN  = 3;

   logic               clk_i = 1'b0;
   logic               rst_i = 1'b1;
   logic               req_valid_i = 1'b0;
   logic               req_ready_o;
   logic [INDEX_W-1:0] req_set_i = '0;
   logic [2:0]         req_way_i = '0;
   logic [TAG_W-1:0]   req_tag_i = '0;
   logic               req_line_valid_i = 1'b0;
   logic               req_dirty_i = 1'b0;
   logic [1:0]         req_perm_i = '0;
   logic               rd_en_o;
   logic [INDEX_W-1:0] rd_set_o;
   logic [2:0]         rd_way_o;
   logic [2:0]         rd_beat_o;
   logic [63:0]        rd_data_i = '0;
   logic               c_valid_o;
   logic               c_ready_i = 1'b1;
   logic [2:0]         c_opcode_o;
   logic [2:0]         c_param_o;
   logic [2:0]         c_size_o;
   logic [3:0]         c_source_o;
   logic [ADDR_W-1:0]  c_address_o;
   logic [63:0]        c_data_o;
   logic               d_valid_i = 1'b0;
   logic               d_ready_o;
   logic [2:0]         d_opcode_i = '0;
   logic [3:0]         d_source_i = '0;
   logic               inval_o;
   logic [INDEX_W-1:0] inval_set_o;
   logic [2:0]         inval_way_o;
   logic               done_o;
   logic               busy_o;

   always #5 clk_i = ~clk_i;

   cpu64_l1_evict #(.INDEX_W(INDEX_W), .ADDR_W(ADDR_W), .SOURCE_ID(0)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_set_i(req_set_i), .req_way_i(req_way_i), .req_tag_i(req_tag_i),
      .req_line_valid_i(req_line_valid_i), .req_dirty_i(req_dirty_i),
      .req_perm_i(req_perm_i),
      .rd_en_o(rd_en_o), .rd_set_o(rd_set_o), .rd_way_o(rd_way_o),
      .rd_beat_o(rd_beat_o), .rd_data_i(rd_data_i),
      .c_valid_o(c_valid_o), .c_ready_i(c_ready_i), .c_opcode_o(c_opcode_o),
      .c_param_o(c_param_o), .c_size_o(c_size_o), .c_source_o(c_source_o),
      .c_address_o(c_address_o), .c_data_o(c_data_o),
      .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_opcode_i(d_opcode_i),
      .d_source_i(d_source_i),
      .inval_o(inval_o), .inval_set_o(inval_set_o), .inval_way_o(inval_way_o),
      .done_o(done_o), .busy_o(busy_o)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Data array contents: set 0 / way 0 holds 0x1000 + beat.
   function automatic logic [63:0] mem_fn(input logic [4:0] s, input logic [2:0] w, input logic [2:0] b);
      logic [63:0] k;
      k = 64'({s, w});
      return (k * 64'h9E37_79B9_7F4A_7C15) + 64'h1000 + 64'(b);
   endfunction

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  prm;
      logic [31:0] addr;
      logic [63:0] data;
      bit          has_data;
   } beat_t;

   // Reference model state.
   beat_t       exp_q[$];
   int          ph = P_IDLE;
   logic [4:0]  m_set;
   logic [2:0]  m_way;
   bit          m_dirty, m_inval, m_rd;
   int          m_sent = 0;
   int          cyc = 0;
   int          acc_cyc = 0, done_cyc = 0;
   int          dones = 0, accepts = 0, rd_cnt = 0, c_hs = 0;
   logic [63:0] seen_data[$];
   bit          seen_inval;
   logic [4:0]  seen_set;
   logic [2:0]  seen_way;
   logic [TAG_W-1:0] last_tag;

   // Every-cycle comparison against the model, then model advance.
   always @(negedge clk_i) begin
      bit    exp_rd, exp_cv, exp_dr;
      beat_t b;
      cyc++;
      if (rst_i) begin
         ph = P_IDLE;
         exp_q.delete();
         m_rd = 1'b0;
         m_sent = 0;
      end else begin
         exp_rd = (ph == P_BUS) && m_dirty && !m_rd;
         exp_cv = (ph == P_BUS) && (!m_dirty || m_rd);
         exp_dr = (ph == P_ACK) && (d_opcode_i == 3'd6) && (d_source_i == 4'd0);
         chk("req_ready", 64'(req_ready_o), 64'(ph == P_IDLE));
         chk("busy",      64'(busy_o),      64'(ph != P_IDLE));
         chk("done",      64'(done_o),      64'(ph == P_FIN));
         chk("inval",     64'(inval_o),     64'(ph == P_FIN && m_inval));
         chk("rd_en",     64'(rd_en_o),     64'(exp_rd));
         chk("c_valid",   64'(c_valid_o),   64'(exp_cv));
         chk("d_ready",   64'(d_ready_o),   64'(exp_dr));
         if (rd_en_o) rd_cnt++;
         if (rd_en_o && exp_rd) begin
            chk("rd_set",  64'(rd_set_o),  64'(m_set));
            chk("rd_way",  64'(rd_way_o),  64'(m_way));
            chk("rd_beat", 64'(rd_beat_o), 64'(m_sent));
         end
         if (inval_o && ph == P_FIN && m_inval) begin
            chk("inval_set", 64'(inval_set_o), 64'(m_set));
            chk("inval_way", 64'(inval_way_o), 64'(m_way));
         end
         if (c_valid_o && exp_cv && exp_q.size() > 0) begin
            chk("c_opcode",  64'(c_opcode_o),  64'(exp_q[0].op));
            chk("c_param",   64'(c_param_o),   64'(exp_q[0].prm));
            chk("c_size",    64'(c_size_o),    64'd6);
            chk("c_source",  64'(c_source_o),  64'd0);
            chk("c_address", 64'(c_address_o), 64'(exp_q[0].addr));
            if (exp_q[0].has_data) chk("c_data", c_data_o, exp_q[0].data);
         end
         if (done_o) begin
            seen_inval = inval_o;
            seen_set   = inval_set_o;
            seen_way   = inval_way_o;
            done_cyc   = cyc;
         end
         case (ph)
            P_IDLE: if (req_valid_i) begin
               accepts++;
               acc_cyc  = cyc;
               last_tag = req_tag_i;
               m_set    = req_set_i;
               m_way    = req_way_i;
               m_dirty  = req_dirty_i;
               m_inval  = req_line_valid_i && (req_perm_i != 2'd0);
               m_rd     = 1'b0;
               m_sent   = 0;
               chk("legal_req", 64'(req_line_valid_i && req_dirty_i && req_perm_i == 2'd1), 64'd0);
               if (!m_inval) ph = P_FIN;
               else begin
                  for (int i = 0; i < (req_dirty_i ? 8 : 1); i++) begin
                     b.op       = req_dirty_i ? 3'd7 : 3'd6;
                     b.prm      = (req_perm_i == 2'd2) ? 3'd1 : 3'd2;
                     b.addr     = {req_tag_i, req_set_i, 6'b0};
                     b.data     = mem_fn(req_set_i, req_way_i, 3'(i));
                     b.has_data = req_dirty_i;
                     exp_q.push_back(b);
                  end
                  ph = P_BUS;
               end
            end
            P_BUS: begin
               if (exp_rd) m_rd = 1'b1;
               else if (exp_cv && c_ready_i) begin
                  void'(exp_q.pop_front());
                  seen_data.push_back(c_data_o);
                  c_hs++;
                  m_sent++;
                  m_rd = 1'b0;
                  if (exp_q.size() == 0) ph = P_ACK;
               end
            end
            P_ACK: if (d_valid_i && exp_dr) ph = P_FIN;
            default: begin
               ph = P_IDLE;
               dones++;
            end
         endcase
      end
   end

   // Data array: answers the cycle after a strobe, garbage otherwise.
   initial begin
      logic [63:0] v;
      forever begin
         @(posedge clk_i);
         v = rd_en_o ? mem_fn(rd_set_o, rd_way_o, rd_beat_o) : {$urandom, $urandom};
         #1 rd_data_i = v;
      end
   end

   // Channel C ready: 0 always, 1 random, 2 three-cycle stall on beat 2.
   int c_mode = 0;
   int stall_cnt = 0;
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         case (c_mode)
            0: c_ready_i = 1'b1;
            1: c_ready_i = ($urandom_range(0, 9) < 6);
            default: begin
               if (c_valid_o && m_sent == 2 && stall_cnt < 3) begin
                  c_ready_i = 1'b0;
                  stall_cnt++;
               end else c_ready_i = 1'b1;
            end
         endcase
      end
   end

   // Channel D: 0 random traffic, 1 driven by the main sequence, 2 always a good ack.
   int d_mode = 0;
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         if (d_mode == 0) begin
            d_valid_i  = 1'($urandom_range(0, 1));
            d_opcode_i = ($urandom_range(0, 1) != 0) ? 3'd6 : 3'($urandom_range(0, 7));
            d_source_i = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
         end else if (d_mode == 2) begin
            d_valid_i  = 1'b1;
            d_opcode_i = 3'd6;
            d_source_i = 4'd0;
         end
      end
   end

   initial begin
      repeat (80000) @(posedge clk_i);
      fails++;
      $display("FAIL watchdog: cycle budget exhausted");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_req(input logic [4:0] s, input logic [2:0] w, input logic [TAG_W-1:0] t,
                           input logic lv, input logic d, input logic [1:0] p);
      int n = 0;
      while (!req_ready_o && n < 500) begin tick(); n++; end
      if (n >= 500) chk("req_ready_timeout", 64'(req_ready_o), 64'd1);
      req_valid_i = 1'b1; req_set_i = s; req_way_i = w; req_tag_i = t;
      req_line_valid_i = lv; req_dirty_i = d; req_perm_i = p;
      tick();
      req_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (dones < target && n < 2000) begin tick(); n++; end
      chk("done_timeout", 64'(dones >= target), 64'd1);
   endtask

   initial begin
      int d0, a0, h0, n, dA;
      repeat (3) tick();
      rst_i = 1'b0;
      tick();
      // Reset state.
      chk("rst_req_ready", 64'(req_ready_o), 64'd1);
      chk("rst_busy",      64'(busy_o),      64'd0);
      chk("rst_c_valid",   64'(c_valid_o),   64'd0);
      chk("rst_c_address", 64'(c_address_o), 64'd0);
      chk("rst_rd_en",     64'(rd_en_o),     64'd0);
      chk("rst_done",      64'(done_o),      64'd0);
      chk("rst_inval",     64'(inval_o),     64'd0);
      chk("rst_d_ready",   64'(d_ready_o),   64'd0);

      // Clean T line, set 3 way 5 tag 0x1234.
      c_mode = 0; d_mode = 2;
      d0 = dones;
      send_req(5'd3, 3'd5, 21'h1234, 1'b1, 1'b0, 2'd2);
      chk("t1_c_valid", 64'(c_valid_o),   64'd1);
      chk("t1_addr",    64'(c_address_o), 64'h0091_A0C0);
      chk("t1_opcode",  64'(c_opcode_o),  64'd6);
      chk("t1_param",   64'(c_param_o),   64'd1);
      wait_done(d0 + 1);
      chk("t1_inval", 64'(seen_inval), 64'd1);
      chk("t1_set",   64'(seen_set),   64'd3);
      chk("t1_way",   64'(seen_way),   64'd5);

      // Dirty T line with a stall on beat 2.
      c_mode = 2; stall_cnt = 0; rd_cnt = 0; seen_data.delete();
      d0 = dones;
      send_req(5'd0, 3'd0, 21'h0ABCD, 1'b1, 1'b1, 2'd2);
      wait_done(d0 + 1);
      chk("t2_beats", 64'(seen_data.size()), 64'd8);
      if (seen_data.size() == 8) begin
         chk("t2_data0", seen_data[0], 64'h1000);
         chk("t2_data2", seen_data[2], 64'h1002);
         chk("t2_data7", seen_data[7], 64'h1007);
      end
      chk("t2_rd_pulses", 64'(rd_cnt),    64'd8);
      chk("t2_stalls",    64'(stall_cnt), 64'd3);

      // Invalid victim: no bus traffic, done the cycle after accept.
      c_mode = 0; d_mode = 0;
      d0 = dones; h0 = c_hs;
      send_req(5'd9, 3'd1, 21'h00077, 1'b0, 1'b1, 2'd2);
      wait_done(d0 + 1);
      chk("t3_latency", 64'(done_cyc - acc_cyc), 64'd1);
      chk("t3_inval",   64'(seen_inval),         64'd0);
      chk("t3_no_c",    64'(c_hs - h0),          64'd0);

      // Non-matching D beats are left waiting.
      d_mode = 1; d_valid_i = 1'b0;
      d0 = dones;
      send_req(5'd12, 3'd6, 21'h1F00F, 1'b1, 1'b0, 2'd1);
      n = 0;
      while (ph != P_ACK && n < 100) begin tick(); n++; end
      chk("t4_reach_ack", 64'(ph == P_ACK), 64'd1);
      d_valid_i = 1'b1; d_opcode_i = 3'd1; d_source_i = 4'd0;
      tick();
      chk("t4_bad_op_ready", 64'(d_ready_o), 64'd0);
      chk("t4_bad_op_busy",  64'(busy_o),    64'd1);
      d_opcode_i = 3'd6; d_source_i = 4'd5;
      tick();
      chk("t4_bad_src_ready", 64'(d_ready_o), 64'd0);
      chk("t4_bad_src_busy",  64'(busy_o),    64'd1);
      d_source_i = 4'd0;
      #1;
      chk("t4_good_ready", 64'(d_ready_o), 64'd1);
      wait_done(d0 + 1);
      d_valid_i = 1'b0;
      d_mode = 0;

      // Reset in the middle of beat 4 of a dirty release.
      c_mode = 0; d_mode = 2;
      d0 = dones;
      send_req(5'd20, 3'd3, 21'h12345, 1'b1, 1'b1, 2'd2);
      n = 0;
      while (!(c_valid_o && m_sent == 4) && n < 100) begin tick(); n++; end
      chk("t5_reach_beat4", 64'(m_sent), 64'd4);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("t5_c_valid",   64'(c_valid_o),   64'd0);
      chk("t5_req_ready", 64'(req_ready_o), 64'd1);
      chk("t5_done",      64'(done_o),      64'd0);
      chk("t5_no_done",   64'(dones),       64'(d0));
      send_req(5'd21, 3'd4, 21'h00ABC, 1'b1, 1'b0, 2'd2);
      wait_done(d0 + 1);

      // Request held high while busy: second accepted the cycle after FIN.
      a0 = accepts; dA = dones;
      while (!req_ready_o) tick();
      req_valid_i = 1'b1; req_set_i = 5'd1; req_way_i = 3'd1; req_tag_i = 21'h00111;
      req_line_valid_i = 1'b1; req_dirty_i = 1'b0; req_perm_i = 2'd2;
      tick();
      req_set_i = 5'd2; req_way_i = 3'd2; req_tag_i = 21'h00222; req_perm_i = 2'd1;
      n = 0;
      while (accepts < a0 + 2 && n < 200) begin tick(); n++; end
      req_valid_i = 1'b0;
      chk("t6_accepts",   64'(accepts - a0),        64'd2);
      chk("t6_gap",       64'(acc_cyc - done_cyc),  64'd1);
      chk("t6_tag",       64'(last_tag),            64'h00222);
      wait_done(dA + 2);

      // Randomized requests with random C back-pressure and D traffic.
      c_mode = 1; d_mode = 0;
      d0 = dones;
      repeat (3000) begin
         req_valid_i      = 1'($urandom_range(0, 1));
         req_set_i        = 5'($urandom);
         req_way_i        = 3'($urandom);
         req_tag_i        = TAG_W'($urandom);
         req_line_valid_i = ($urandom_range(0, 7) != 0);
         req_dirty_i      = 1'($urandom_range(0, 1));
         req_perm_i       = 2'($urandom_range(0, 2));
         if (req_dirty_i && req_perm_i == 2'd1) req_perm_i = 2'd2;
         tick();
      end
      req_valid_i = 1'b0;
      n = 0;
      while ((ph != P_IDLE || busy_o) && n < 3000) begin tick(); n++; end
      chk("rand_drain",    64'(busy_o),          64'd0);
      chk("rand_progress", 64'(dones - d0 > 20), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
